// File: rtl/aes_dispatch.sv
// Spreads an input block stream round-robin over NCH AES engines and returns the
// results in acceptance order. It also sequences key expansion, which waits until every engine is idle.
module aes_dispatch #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               KEY_START,
    output logic               KEY_BUSY,
    input  logic               S_VALID,
    output logic               S_READY,
    input  logic [127:0]       S_DATA,
    input  logic               S_MODE,
    output logic               M_VALID,
    input  logic               M_READY,
    output logic [127:0]       M_DATA,
    output logic [NCH-1:0]     ENG_START_CIPHER,
    output logic [NCH-1:0]     ENG_START_KEYEXP,
    output logic [NCH-1:0]     ENG_OP_MODE,
    output logic [NCH*128-1:0] ENG_DATA_IN,
    input  logic [NCH*128-1:0] ENG_DATA_OUT,
    input  logic [NCH-1:0]     ENG_OP_FINISH,
    input  logic [NCH-1:0]     ENG_EXP_FINISH,
    output logic [CNT_W-1:0]   BLK_CNT,
    output logic               PROT_ERR
);
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {NOKEY, KEY_DRAIN, KEY_ISSUE, KEY_WAIT, RUN} state_t;
    typedef enum logic [1:0] {CH_FREE, CH_BUSY, CH_DONE} ch_t;

    state_t                r_state, w_state_nxt;
    ch_t                   r_ch [NCH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [NCH-1:0]        r_exp_done, r_exp_prev, r_op_prev, r_start, r_mode;
    logic [NCH-1:0][127:0] r_din, r_res;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;
    logic                  w_s_fire, w_m_fire, w_all_free;
    logic [NCH-1:0]        w_exp_rise, w_op_rise, w_busy;

    assign S_READY          = (r_state == RUN) && (r_ch[r_wr_ptr] == CH_FREE);
    assign M_VALID          = (r_ch[r_rd_ptr] == CH_DONE);
    assign M_DATA           = r_res[r_rd_ptr];
    assign KEY_BUSY         = (r_state == KEY_DRAIN) || (r_state == KEY_ISSUE) || (r_state == KEY_WAIT);
    assign ENG_START_KEYEXP = {NCH{r_state == KEY_ISSUE}};
    assign ENG_START_CIPHER = r_start;
    assign ENG_OP_MODE      = r_mode;
    assign ENG_DATA_IN      = r_din;
    assign BLK_CNT          = r_cnt;
    assign PROT_ERR         = r_err;

    assign w_s_fire   = S_VALID && S_READY;
    assign w_m_fire   = M_VALID && M_READY;
    assign w_exp_rise = ENG_EXP_FINISH & ~r_exp_prev;
    assign w_op_rise  = ENG_OP_FINISH & ~r_op_prev;

    always_comb begin
        w_all_free = 1'b1;
        w_busy     = '0;
        for (int c = 0; c < NCH; c++) begin
            w_busy[c] = (r_ch[c] == CH_BUSY);
            if (r_ch[c] != CH_FREE) w_all_free = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            NOKEY, RUN: if (KEY_START) w_state_nxt = KEY_DRAIN;
            KEY_DRAIN:  if (w_all_free) w_state_nxt = KEY_ISSUE;
            KEY_ISSUE:  w_state_nxt = KEY_WAIT;
            KEY_WAIT:   if (&r_exp_done) w_state_nxt = RUN;
            default:    w_state_nxt = NOKEY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) r_state <= NOKEY;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_exp_done <= '0;
            r_exp_prev <= '0;
            r_op_prev  <= '0;
            r_start    <= '0;
            r_mode     <= '0;
            r_din      <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            for (int c = 0; c < NCH; c++) r_ch[c] <= CH_FREE;
        end else begin
            r_exp_prev <= ENG_EXP_FINISH;
            r_op_prev  <= ENG_OP_FINISH;
            r_start    <= '0;
            if (w_s_fire) begin
                r_din[r_wr_ptr]   <= S_DATA;
                r_mode[r_wr_ptr]  <= S_MODE;
                r_start[r_wr_ptr] <= 1'b1;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(NCH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_m_fire) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(NCH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            if (r_state == KEY_ISSUE)     r_exp_done <= '0;
            else if (r_state == KEY_WAIT) r_exp_done <= r_exp_done | w_exp_rise;
            // Finish edges on idle channels, or key completions we never asked for, are logged only
            if ((w_op_rise & ~w_busy) != '0 || (r_state != KEY_WAIT && w_exp_rise != '0))
                r_err <= 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (w_s_fire && r_wr_ptr == PTR_W'(c)) begin
                    r_ch[c] <= CH_BUSY;
                end else if (r_ch[c] == CH_BUSY && w_op_rise[c]) begin
                    r_ch[c]  <= CH_DONE;
                    r_res[c] <= ENG_DATA_OUT[128*c +: 128];
                end else if (w_m_fire && r_rd_ptr == PTR_W'(c)) begin
                    r_ch[c] <= CH_FREE;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_dispatch.sv
// Directed bench for aes_dispatch: behavioural engines with per-channel latency,
// result = input XOR A5-pattern; inputs driven and outputs sampled around the falling edge.
module tb_aes_dispatch;
    localparam int NCH   = 4;
    localparam int CNT_W = 32;
    localparam logic [127:0] MASK = {16{8'hA5}};

    logic                  CLK = 1'b0, RESETn = 1'b0, KEY_START = 1'b0;
    logic                  S_VALID = 1'b0, S_MODE = 1'b0, M_READY = 1'b0;
    logic [127:0]          S_DATA = '0;
    logic                  KEY_BUSY, S_READY, M_VALID, PROT_ERR;
    logic [127:0]          M_DATA;
    logic [NCH-1:0]        ENG_START_CIPHER, ENG_START_KEYEXP, ENG_OP_MODE, ENG_OP_FINISH;
    logic [NCH*128-1:0]    ENG_DATA_IN;
    logic [CNT_W-1:0]      BLK_CNT;
    logic [NCH-1:0]        exp_fin = '0, mfin = '0, spur_en = '0, spur_val = '0;
    logic [NCH-1:0][127:0] mout = '0, mdin = '0;
    int                    lat [NCH];
    int                    cnt [NCH];
    logic                  mode_log [$];
    logic [127:0]          rx_q [$];
    int                    n_chk = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    assign ENG_OP_FINISH = (spur_en & spur_val) | (~spur_en & mfin);

    aes_dispatch #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESETn(RESETn), .KEY_START(KEY_START), .KEY_BUSY(KEY_BUSY),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_MODE(S_MODE),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .ENG_START_CIPHER(ENG_START_CIPHER), .ENG_START_KEYEXP(ENG_START_KEYEXP),
        .ENG_OP_MODE(ENG_OP_MODE), .ENG_DATA_IN(ENG_DATA_IN), .ENG_DATA_OUT(mout),
        .ENG_OP_FINISH(ENG_OP_FINISH), .ENG_EXP_FINISH(exp_fin),
        .BLK_CNT(BLK_CNT), .PROT_ERR(PROT_ERR)
    );

    // Engine model: start pulse drops finish, finish rises lat[c] cycles later with the result
    always @(negedge CLK) begin
        for (int c = 0; c < NCH; c++) begin
            if (ENG_START_CIPHER[c]) begin
                cnt[c]  = lat[c];
                mfin[c] = 1'b0;
                mdin[c] = ENG_DATA_IN[128*c +: 128];
                mode_log.push_back(ENG_OP_MODE[c]);
            end else if (cnt[c] > 0) begin
                cnt[c]--;
                if (cnt[c] == 0) begin
                    mfin[c] = 1'b1;
                    mout[c] = mdin[c] ^ MASK;
                end
            end
        end
    end

    task automatic stream(input int n, input logic [127:0] base, output bit tmo);
        int sent = 0, rcvd = 0, cyc = 0;
        rx_q.delete();
        M_READY = 1'b1;
        while ((sent < n || rcvd < n) && cyc < 2000) begin
            S_VALID = (sent < n);
            S_DATA  = base + 128'(sent);
            S_MODE  = sent[0];
            #1;
            if (S_VALID && S_READY) sent++;
            if (M_VALID) begin rx_q.push_back(M_DATA); rcvd++; end
            @(negedge CLK);
            cyc++;
        end
        S_VALID = 1'b0;
        tmo = (sent < n || rcvd < n);
    endtask

    task automatic test_reset();
        RESETn = 1'b0; S_VALID = 1'b1; M_READY = 1'b1; S_DATA = '1; S_MODE = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        n_chk++; if ({S_READY, M_VALID, KEY_BUSY, PROT_ERR} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {S_READY, M_VALID, KEY_BUSY, PROT_ERR}); end
        n_chk++; if (BLK_CNT !== '0) begin n_fail++; $display("FAIL reset_blk_cnt: got %0d want 0", BLK_CNT); end
        n_chk++; if ({ENG_START_CIPHER, ENG_START_KEYEXP, ENG_OP_MODE} !== '0) begin n_fail++; $display("FAIL reset_eng_ctl: got %h want 0", {ENG_START_CIPHER, ENG_START_KEYEXP, ENG_OP_MODE}); end
        n_chk++; if (ENG_DATA_IN !== '0) begin n_fail++; $display("FAIL reset_eng_data: got %h want 0", ENG_DATA_IN); end
        n_chk++; if (M_DATA !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", M_DATA); end
        RESETn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); #1;
            n_chk++;
            if ({S_READY, M_VALID, KEY_BUSY, PROT_ERR, ENG_START_CIPHER, ENG_START_KEYEXP, ENG_OP_MODE} !== '0 || BLK_CNT !== '0) begin
                n_fail++;
                $display("FAIL nokey_idle cyc %0d: rdy=%b mv=%b busy=%b err=%b ctl=%h cnt=%0d want all 0",
                         i, S_READY, M_VALID, KEY_BUSY, PROT_ERR, {ENG_START_CIPHER, ENG_START_KEYEXP, ENG_OP_MODE}, BLK_CNT);
            end
        end
        S_VALID = 1'b0;
    endtask

    task automatic test_key_expansion();
        int bad = 0;
        KEY_START = 1'b1;
        @(negedge CLK); KEY_START = 1'b0; #1;
        n_chk++; if (KEY_BUSY !== 1'b1) begin n_fail++; $display("FAIL key_drain_busy: got %b want 1", KEY_BUSY); end
        n_chk++; if (ENG_START_KEYEXP !== 4'h0) begin n_fail++; $display("FAIL key_drain_keyexp: got %h want 0", ENG_START_KEYEXP); end
        @(negedge CLK); #1;
        n_chk++; if (ENG_START_KEYEXP !== 4'hF) begin n_fail++; $display("FAIL key_issue_keyexp: got %h want f", ENG_START_KEYEXP); end
        exp_fin = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK); #1;
            if (KEY_BUSY !== 1'b1 || ENG_START_KEYEXP !== 4'h0 || S_READY !== 1'b0) bad++;
            if (k == 5)  exp_fin[0] = 1'b1;
            if (k == 9)  exp_fin[1] = 1'b1;
            if (k == 12) exp_fin[2] = 1'b1;
            if (k == 20) exp_fin[3] = 1'b1;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL key_wait_hold: %0d bad cycles want 0", bad); end
        @(negedge CLK); #1;
        n_chk++; if (KEY_BUSY !== 1'b1) begin n_fail++; $display("FAIL key_busy_edge_cycle: got %b want 1", KEY_BUSY); end
        @(negedge CLK); #1;
        n_chk++; if (KEY_BUSY !== 1'b0) begin n_fail++; $display("FAIL key_busy_fall: got %b want 0", KEY_BUSY); end
        n_chk++; if (S_READY !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b want 1", S_READY); end
        n_chk++; if (PROT_ERR !== 1'b0) begin n_fail++; $display("FAIL key_prot_err: got %b want 0", PROT_ERR); end
    endtask

    task automatic test_stream();
        bit tmo;
        for (int c = 0; c < NCH; c++) lat[c] = 15;
        mode_log.delete();
        stream(8, 128'h0, tmo);
        n_chk++; if (tmo) begin n_fail++; $display("FAIL stream_timeout: got %0d blocks want 8", rx_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (i >= rx_q.size() || rx_q[i] !== (128'(i) ^ MASK)) begin
                n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 128'hx, 128'(i) ^ MASK);
            end
        end
        n_chk++; if (BLK_CNT !== 32'd8) begin n_fail++; $display("FAIL stream_blk_cnt: got %0d want 8", BLK_CNT); end
        n_chk++; if (PROT_ERR !== 1'b0) begin n_fail++; $display("FAIL stream_prot_err: got %b want 0", PROT_ERR); end
        n_chk++; if (mode_log.size() != 8) begin n_fail++; $display("FAIL stream_starts: got %0d want 8", mode_log.size()); end
        for (int i = 0; i < 8 && i < mode_log.size(); i++) begin
            n_chk++; if (mode_log[i] !== i[0]) begin n_fail++; $display("FAIL stream_mode[%0d]: got %b want %b", i, mode_log[i], i[0]); end
        end
    endtask

    task automatic test_order();
        bit tmo;
        lat[0] = 30; lat[1] = 5;
        stream(2, 128'h100, tmo);
        n_chk++; if (tmo) begin n_fail++; $display("FAIL order_timeout: got %0d blocks want 2", rx_q.size()); end
        n_chk++; if (rx_q.size() < 1 || rx_q[0] !== (128'h100 ^ MASK)) begin n_fail++; $display("FAIL order_first: got %h want %h", (rx_q.size() > 0) ? rx_q[0] : 128'hx, 128'h100 ^ MASK); end
        n_chk++; if (rx_q.size() < 2 || rx_q[1] !== (128'h101 ^ MASK)) begin n_fail++; $display("FAIL order_second: got %h want %h", (rx_q.size() > 1) ? rx_q[1] : 128'hx, 128'h101 ^ MASK); end
        n_chk++; if (BLK_CNT !== 32'd10) begin n_fail++; $display("FAIL order_blk_cnt: got %0d want 10", BLK_CNT); end
    endtask

    task automatic test_backpressure();
        int acc = 0, rcvd = 0;
        logic [127:0] base = 128'h200;
        for (int c = 0; c < NCH; c++) lat[c] = 3;
        rx_q.delete();
        M_READY = 1'b0; S_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            S_DATA = base + 128'(acc);
            #1;
            if (S_READY) acc++;
            @(negedge CLK);
        end
        #1;
        n_chk++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        n_chk++; if (S_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", S_READY); end
        n_chk++; if (M_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid: got %b want 1", M_VALID); end
        S_DATA = base + 128'd4; M_READY = 1'b1;
        #1;
        n_chk++; if (S_READY !== 1'b0) begin n_fail++; $display("FAIL bp_no_bypass: got %b want 0", S_READY); end
        rx_q.push_back(M_DATA);
        @(negedge CLK); M_READY = 1'b0; #1;
        n_chk++; if (S_READY !== 1'b1) begin n_fail++; $display("FAIL bp_freed_next: got %b want 1", S_READY); end
        @(negedge CLK); S_VALID = 1'b0; #1;
        n_chk++; if (S_READY !== 1'b0) begin n_fail++; $display("FAIL bp_full_again: got %b want 0", S_READY); end
        M_READY = 1'b1;
        for (int i = 0; i < 40 && rcvd < 4; i++) begin
            if (M_VALID) begin rx_q.push_back(M_DATA); rcvd++; end
            @(negedge CLK); #1;
        end
        n_chk++; if (rcvd != 4) begin n_fail++; $display("FAIL bp_drain: got %0d want 4", rcvd); end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (i >= rx_q.size() || rx_q[i] !== ((base + 128'(i)) ^ MASK)) begin
                n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 128'hx, (base + 128'(i)) ^ MASK);
            end
        end
        n_chk++; if (BLK_CNT !== 32'd15) begin n_fail++; $display("FAIL bp_blk_cnt: got %0d want 15", BLK_CNT); end
    endtask

    task automatic test_key_drain();
        int  acc = 0, rcvd = 0, rdy_seen = 0, kx_early = 0;
        bit  kx = 1'b0;
        for (int c = 0; c < NCH; c++) lat[c] = 10;
        rx_q.delete();
        M_READY = 1'b0; S_VALID = 1'b1;
        for (int i = 0; i < 20 && acc < 2; i++) begin
            S_DATA = 128'h300 + 128'(acc);
            #1;
            if (S_READY) acc++;
            @(negedge CLK);
        end
        S_VALID = 1'b0;
        n_chk++; if (acc != 2) begin n_fail++; $display("FAIL drain_accepts: got %0d want 2", acc); end
        KEY_START = 1'b1;
        @(negedge CLK); KEY_START = 1'b0; S_VALID = 1'b1; #1;
        n_chk++; if (KEY_BUSY !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1", KEY_BUSY); end
        for (int i = 0; i < 20; i++) begin
            if (S_READY) rdy_seen++;
            if (ENG_START_KEYEXP !== 4'h0) kx_early++;
            @(negedge CLK); #1;
        end
        n_chk++; if (rdy_seen != 0) begin n_fail++; $display("FAIL drain_ready: got %0d ready cycles want 0", rdy_seen); end
        n_chk++; if (kx_early != 0) begin n_fail++; $display("FAIL drain_early_keyexp: got %0d pulses want 0", kx_early); end
        S_VALID = 1'b0; M_READY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (M_VALID) begin rx_q.push_back(M_DATA); rcvd++; end
            if (ENG_START_KEYEXP !== 4'h0) begin
                kx = 1'b1;
                n_chk++; if (rcvd != 2) begin n_fail++; $display("FAIL drain_keyexp_order: got %0d delivered want 2", rcvd); end
                exp_fin = '0;
                break;
            end
            @(negedge CLK); #1;
        end
        n_chk++; if (!kx) begin n_fail++; $display("FAIL drain_keyexp_timeout: got no pulse want one"); end
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (i >= rx_q.size() || rx_q[i] !== ((128'h300 + 128'(i)) ^ MASK)) begin
                n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 128'hx, (128'h300 + 128'(i)) ^ MASK);
            end
        end
        @(negedge CLK); exp_fin = '1;
        for (int i = 0; i < 10 && KEY_BUSY; i++) begin @(negedge CLK); #1; end
        n_chk++; if (KEY_BUSY !== 1'b0) begin n_fail++; $display("FAIL drain_key_done: got %b want 0", KEY_BUSY); end
        n_chk++; if (BLK_CNT !== 32'd17) begin n_fail++; $display("FAIL drain_blk_cnt: got %0d want 17", BLK_CNT); end
        n_chk++; if (PROT_ERR !== 1'b0) begin n_fail++; $display("FAIL pre_spur_err: got %b want 0", PROT_ERR); end
        spur_en[2] = 1'b1; spur_val[2] = 1'b0;
        @(negedge CLK); spur_val[2] = 1'b1;
        @(negedge CLK); #1;
        n_chk++; if (PROT_ERR !== 1'b1) begin n_fail++; $display("FAIL spur_err_set: got %b want 1", PROT_ERR); end
        spur_en = '0;
        repeat (5) @(negedge CLK);
        #1;
        n_chk++; if (PROT_ERR !== 1'b1) begin n_fail++; $display("FAIL spur_err_sticky: got %b want 1", PROT_ERR); end
        n_chk++; if (M_VALID !== 1'b0 || BLK_CNT !== 32'd17) begin n_fail++; $display("FAIL spur_ignored: mv=%b cnt=%0d want 0/17", M_VALID, BLK_CNT); end
    endtask

    task automatic test_reset_midflight();
        int mv_seen = 0;
        for (int c = 0; c < NCH; c++) lat[c] = 40;
        M_READY = 1'b1; S_VALID = 1'b1; S_DATA = 128'h400;
        #1;
        n_chk++; if (S_READY !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", S_READY); end
        @(negedge CLK); S_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RESETn = 1'b0;
        @(negedge CLK); RESETn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK); #1;
            if (M_VALID) mv_seen++;
        end
        n_chk++; if (mv_seen != 0) begin n_fail++; $display("FAIL mid_abandon: got %0d valid cycles want 0", mv_seen); end
        n_chk++; if (BLK_CNT !== '0) begin n_fail++; $display("FAIL mid_blk_cnt: got %0d want 0", BLK_CNT); end
        n_chk++; if (S_READY !== 1'b0 || KEY_BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_nokey: rdy=%b busy=%b want 0/0", S_READY, KEY_BUSY); end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) lat[c] = 15;
        test_reset();
        test_key_expansion();
        test_stream();
        test_order();
        test_backpressure();
        test_key_drain();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_dispatch.md
AES_DISPATCH -- requirements
Module: aes_dispatch

Interface
REQ-001 Parameter: NCH, default 4, number of attached AES engines (1..8).
REQ-002 Parameter: CNT_W, default 32, width of completed-block counter.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 RESETn  in  1  reset, synchronous, active-low.
REQ-005 KEY_START  in  1  one-cycle request to (re)run key expansion on all engines.
REQ-006 KEY_BUSY  out  1  high while key expansion pending or in progress.
REQ-007 S_VALID / S_READY  in / out  1 / 1  input block handshake.
REQ-008 S_DATA  in  128  input block; S_MODE  in  1  1 = encipher, 0 = decipher.
REQ-009 M_VALID / M_READY  out / in  1 / 1  output block handshake.
REQ-010 M_DATA  out  128  result block.
REQ-011 ENG_START_CIPHER, ENG_START_KEYEXP, ENG_OP_MODE  out  NCH each  per-engine controls.
REQ-012 ENG_DATA_IN  out  NCH*128  engine inputs, channel c at bits [128c+127:128c].
REQ-013 ENG_DATA_OUT  in  NCH*128  engine outputs, same packing.
REQ-014 ENG_OP_FINISH, ENG_EXP_FINISH  in  NCH each  engine completion levels.
REQ-015 BLK_CNT  out  CNT_W  count of blocks delivered on M.
REQ-016 PROT_ERR  out  1  sticky protocol-error flag.

Function
REQ-017 Top FSM states: NOKEY, KEY_DRAIN, KEY_ISSUE, KEY_WAIT, RUN.
REQ-018 Transitions: NOKEY/RUN --KEY_START--> KEY_DRAIN; KEY_DRAIN --all channels FREE--> KEY_ISSUE; KEY_ISSUE --1 cycle--> KEY_WAIT; KEY_WAIT --all exp-done bits set--> RUN.
REQ-019 KEY_ISSUE drives ENG_START_KEYEXP = all ones for exactly one cycle and clears per-channel exp-done bits.
REQ-020 In KEY_WAIT, exp-done[c] sets on the rising edge of ENG_EXP_FINISH[c] (registered previous value 0, current 1).
REQ-021 KEY_BUSY = 1 in KEY_DRAIN, KEY_ISSUE, KEY_WAIT; 0 otherwise. KEY_START outside NOKEY/RUN is ignored.
REQ-022 Per-channel state: FREE, BUSY, DONE; data pointer wr_ptr and collect pointer rd_ptr, both wrap NCH-1 -> 0.
REQ-023 S_READY = (state == RUN) and channel[wr_ptr] FREE; combinational from registered state.
REQ-024 On S_VALID & S_READY: latch S_DATA into ENG_DATA_IN[wr_ptr], S_MODE into ENG_OP_MODE[wr_ptr], channel -> BUSY, wr_ptr increments.
REQ-025 ENG_START_CIPHER[c] pulses high exactly one cycle, the cycle after acceptance; ENG_DATA_IN[c] and ENG_OP_MODE[c] held stable until next acceptance on c.
REQ-026 Rising edge of ENG_OP_FINISH[c] while c BUSY: capture ENG_DATA_OUT[c] into result register c, channel -> DONE.
REQ-027 M_VALID = channel[rd_ptr] DONE; M_DATA = result register rd_ptr; outputs strictly in acceptance order regardless of engine finish order.
REQ-028 On M_VALID & M_READY: channel[rd_ptr] -> FREE, rd_ptr increments, BLK_CNT increments (wraps at 2^CNT_W).
REQ-029 A channel freed by M handshake in cycle t is acceptable on S at cycle t+1 (no same-cycle bypass).
REQ-030 At most NCH blocks outstanding; with M_READY low, S_READY drops after NCH acceptances.
REQ-031 PROT_ERR sets on: OP_FINISH rising edge on a non-BUSY channel; EXP_FINISH rising edge outside KEY_WAIT. Such events are otherwise ignored; only reset clears PROT_ERR.
REQ-032 Blocks accepted before KEY_START all complete and deliver on M before key expansion issues.

Reset
REQ-033 RESETn low at a rising edge: FSM -> NOKEY, all channels FREE, pointers 0, exp-done 0, finish-edge registers 0, result and ENG_DATA_IN registers 0.
REQ-034 During and after reset: S_READY, M_VALID, KEY_BUSY, PROT_ERR, BLK_CNT, all ENG_* outputs = 0.
REQ-035 Reset mid-operation abandons in-flight blocks; no M output is produced for them.

Verification
REQ-036 Reset, then S_VALID=1 without KEY_START -> S_READY stays 0 for 100 cycles, all outputs 0.
REQ-037 NCH=4, KEY_START pulse; bench EXP_FINISH rises on ch0..3 at +5, +9, +12, +20 cycles -> ENG_START_KEYEXP=4'hF one cycle, KEY_BUSY falls the cycle after ch3 edge.
REQ-038 Stream 8 blocks 0x0..0x7, engine model latency 15, output = input XOR 128'hA5 repeated -> M delivers 8 blocks in order, BLK_CNT=8, PROT_ERR=0.
REQ-039 Engine latencies ch0=30, ch1=5, two blocks -> M delivers ch0 result first, then ch1.
REQ-040 M_READY=0, S_VALID=1 continuous -> exactly 4 acceptances, then S_READY=0; M_READY=1 resumes flow, no loss.
REQ-041 KEY_START with 2 blocks in flight -> S_READY=0, both results delivered, then keyexp pulse; spurious OP_FINISH edge on FREE ch2 -> PROT_ERR=1 sticky.
